brick_field: RTL and testbench

Brick-wall store and collision scanner for the Arkanoid datapath. It sits directly downstream of the ball state/motion control. On each `check` request it takes the current ball position and radius and scans the brick grid serially, one brick per cycle. It reports the first brick hit together with the bounce axes. It also maintains brick strengths, score, bricks-remaining and level-clear, and offers a read port for the renderer.

---
 rtl/brick_field.sv | 187 ++++++++++++++++++
 tb/tb_brick_field.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_field.sv
// Brick-wall store and serial collision scanner: one brick per cycle, first hit wins,
// with strength/score/bricks-left bookkeeping and a registered read port for the renderer.
module brick_field #(
    parameter int ROWS  = 4,
    parameter int COLS  = 8,
    parameter int BLK_W = 80,
    parameter int BLK_H = 20,
    parameter int LEFT  = 0,
    parameter int TOP   = 40,
    localparam int N    = ROWS * COLS,
    localparam int IW   = $clog2(N),
    localparam int RW   = $clog2(ROWS),
    localparam int CW   = $clog2(COLS),
    localparam int LW   = $clog2(N + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [2*N-1:0]  level_data,
    input  logic            check,
    input  logic [9:0]      ball_x,
    input  logic [9:0]      ball_y,
    input  logic [5:0]      radius,
    output logic            busy,
    output logic            done,
    output logic            hit,
    output logic            flip_x,
    output logic            flip_y,
    output logic [RW-1:0]   hit_row,
    output logic [CW-1:0]   hit_col,
    output logic [15:0]     score,
    output logic [LW-1:0]   bricks_left,
    output logic            clear,
    input  logic [RW-1:0]   rd_row,
    input  logic [CW-1:0]   rd_col,
    output logic [1:0]      rd_strength
);

    localparam int BW = 11;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t state, next_state;

    logic [1:0]    field [N];
    logic [9:0]    bx, by;
    logic [5:0]    br;
    logic [IW-1:0] k;
    logic [RW-1:0] scan_row;
    logic [CW-1:0] scan_col;

    logic [BW-1:0] cx, cy, rr;
    logic [BW-1:0] ball_x_lo, ball_x_hi, ball_y_lo, ball_y_hi;
    logic [BW-1:0] brick_x_lo, brick_x_hi, brick_y_lo, brick_y_hi;
    logic [1:0]    cur_strength;
    logic          overlap, in_x, in_y, is_hit, last;
    logic [LW-1:0] load_count;
    logic [IW-1:0] rd_idx;

    assign busy   = (state == SCAN);
    assign rd_idx = IW'(rd_row) * IW'(COLS) + IW'(rd_col);

    // Geometry of the brick under test versus the latched ball box; lower bounds clamp at 0.
    always_comb begin
        cx = BW'(bx);
        cy = BW'(by);
        rr = BW'(br);
        ball_x_lo  = (cx >= rr) ? cx - rr : '0;
        ball_x_hi  = cx + rr;
        ball_y_lo  = (cy >= rr) ? cy - rr : '0;
        ball_y_hi  = cy + rr;
        brick_x_lo = BW'(LEFT) + BW'(scan_col) * BW'(BLK_W);
        brick_x_hi = brick_x_lo + BW'(BLK_W - 1);
        brick_y_lo = BW'(TOP) + BW'(scan_row) * BW'(BLK_H);
        brick_y_hi = brick_y_lo + BW'(BLK_H - 1);
        cur_strength = field[k];
        overlap = (ball_x_lo <= brick_x_hi) && (ball_x_hi >= brick_x_lo) &&
                  (ball_y_lo <= brick_y_hi) && (ball_y_hi >= brick_y_lo);
        in_x    = (cx >= brick_x_lo) && (cx <= brick_x_hi);
        in_y    = (cy >= brick_y_lo) && (cy <= brick_y_hi);
        is_hit  = (state == SCAN) && (cur_strength != 2'd0) && overlap;
        last    = (k == IW'(N - 1));
    end

    always_comb begin
        load_count = '0;
        for (int i = 0; i < N; i++) begin
            if (level_data[2*i +: 2] != 2'd0) begin
                load_count = load_count + LW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Load wins over everything, including aborting a scan in progress.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (check && !load) next_state = SCAN;
            SCAN:    if (load || is_hit || last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                field[i] <= '0;
            end
            bx          <= '0;
            by          <= '0;
            br          <= '0;
            k           <= '0;
            scan_row    <= '0;
            scan_col    <= '0;
            done        <= 1'b0;
            hit         <= 1'b0;
            flip_x      <= 1'b0;
            flip_y      <= 1'b0;
            hit_row     <= '0;
            hit_col     <= '0;
            score       <= '0;
            bricks_left <= '0;
            clear       <= 1'b0;
            rd_strength <= '0;
        end else begin
            done        <= 1'b0;
            rd_strength <= field[rd_idx];
            if (load) begin
                for (int i = 0; i < N; i++) begin
                    field[i] <= level_data[2*i +: 2];
                end
                bricks_left <= load_count;
                clear       <= 1'b0;
            end else if (state == IDLE) begin
                if (check) begin
                    bx       <= ball_x;
                    by       <= ball_y;
                    br       <= radius;
                    k        <= '0;
                    scan_row <= '0;
                    scan_col <= '0;
                end
            end else if (is_hit) begin
                field[k] <= cur_strength - 2'd1;
                if (score != '1) begin
                    score <= score + 16'd1;
                end
                if (cur_strength == 2'd1) begin
                    bricks_left <= bricks_left - LW'(1);
                    if (bricks_left == LW'(1)) begin
                        clear <= 1'b1;
                    end
                end
                done    <= 1'b1;
                hit     <= 1'b1;
                flip_x  <= ~in_x;
                flip_y  <= in_x | ~in_y;
                hit_row <= scan_row;
                hit_col <= scan_col;
            end else if (last) begin
                done    <= 1'b1;
                hit     <= 1'b0;
                flip_x  <= 1'b0;
                flip_y  <= 1'b0;
                hit_row <= '0;
                hit_col <= '0;
            end else begin
                k <= k + IW'(1);
                if (scan_col == CW'(COLS - 1)) begin
                    scan_col <= '0;
                    scan_row <= scan_row + RW'(1);
                end else begin
                    scan_col <= scan_col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_brick_field.sv
// Self-checking bench for brick_field: table of scan vectors with a scoreboard queue,
// plus hand-written load/abort/reset sequences.
module tb_brick_field;

    logic        clock = 1'b0;
    logic        reset, load, check;
    logic [63:0] level_data;
    logic [9:0]  ball_x, ball_y;
    logic [5:0]  radius;
    logic        busy, done, hit, flip_x, flip_y;
    logic [1:0]  hit_row;
    logic [2:0]  hit_col;
    logic [15:0] score;
    logic [5:0]  bricks_left;
    logic        clear;
    logic [1:0]  rd_row;
    logic [2:0]  rd_col;
    logic [1:0]  rd_strength;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [5:0]  r;
        int          inject_at;
        logic        e_hit;
        logic        e_fx;
        logic        e_fy;
        logic [1:0]  e_row;
        logic [2:0]  e_col;
        int          e_lat;
        logic [15:0] e_score;
        logic [5:0]  e_left;
        logic        e_clear;
    } scan_vec_t;

    scan_vec_t sb[$];
    scan_vec_t vecs[8];
    scan_vec_t clear_vec;

    localparam logic [63:0] FULL_TWO = {32{2'b10}};

    brick_field dut (
        .clock(clock), .reset(reset), .load(load), .level_data(level_data),
        .check(check), .ball_x(ball_x), .ball_y(ball_y), .radius(radius),
        .busy(busy), .done(done), .hit(hit), .flip_x(flip_x), .flip_y(flip_y),
        .hit_row(hit_row), .hit_col(hit_col), .score(score),
        .bricks_left(bricks_left), .clear(clear),
        .rd_row(rd_row), .rd_col(rd_col), .rd_strength(rd_strength)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one check, then wait (bounded) for done and compare against the queued expectation.
    task automatic applyStimulus(input scan_vec_t v);
        int        offset;
        bit        seen;
        scan_vec_t e;
        sb.push_back(v);
        ball_x = v.x;
        ball_y = v.y;
        radius = v.r;
        check  = 1'b1;
        @(posedge clock); #1;
        check  = 1'b0;
        offset = 1;
        seen   = 1'b0;
        checkOutput({v.name, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (offset == v.inject_at) begin
                ball_x = 10'd120;
                ball_y = 10'd70;
                radius = 6'd5;
                check  = 1'b1;
            end
            @(posedge clock); #1;
            check = 1'b0;
            offset++;
        end
        e = sb.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no done, expected done at offset %0d", e.name, e.e_lat);
        end else begin
            checkOutput({e.name, "_latency"}, 32'(offset), 32'(e.e_lat));
            checkOutput({e.name, "_hit"}, 32'(hit), 32'(e.e_hit));
            checkOutput({e.name, "_flip_x"}, 32'(flip_x), 32'(e.e_fx));
            checkOutput({e.name, "_flip_y"}, 32'(flip_y), 32'(e.e_fy));
            checkOutput({e.name, "_row"}, 32'(hit_row), 32'(e.e_row));
            checkOutput({e.name, "_col"}, 32'(hit_col), 32'(e.e_col));
            checkOutput({e.name, "_score"}, 32'(score), 32'(e.e_score));
            checkOutput({e.name, "_left"}, 32'(bricks_left), 32'(e.e_left));
            checkOutput({e.name, "_clear"}, 32'(clear), 32'(e.e_clear));
            checkOutput({e.name, "_idle"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic applyLoad(input logic [63:0] data);
        level_data = data;
        load = 1'b1;
        @(posedge clock); #1;
        load = 1'b0;
    endtask

    task automatic readBack(input string name, input logic [1:0] row, input logic [2:0] col, input logic [1:0] expected);
        rd_row = row;
        rd_col = col;
        @(posedge clock); #1;
        checkOutput(name, 32'(rd_strength), 32'(expected));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_hit"}, 32'(hit), 32'd0);
        checkOutput({tag, "_flip_x"}, 32'(flip_x), 32'd0);
        checkOutput({tag, "_flip_y"}, 32'(flip_y), 32'd0);
        checkOutput({tag, "_row"}, 32'(hit_row), 32'd0);
        checkOutput({tag, "_col"}, 32'(hit_col), 32'd0);
        checkOutput({tag, "_score"}, 32'(score), 32'd0);
        checkOutput({tag, "_left"}, 32'(bricks_left), 32'd0);
        checkOutput({tag, "_clear"}, 32'(clear), 32'd0);
        checkOutput({tag, "_rd"}, 32'(rd_strength), 32'd0);
    endtask

    task automatic countDone(input string name, input int cycles);
        int dc = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done) dc++;
            @(posedge clock); #1;
        end
        checkOutput(name, 32'(dc), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //            name      x    y    r  inj hit fx fy row col lat score left clr
        vecs[0] = '{"mid",    10'd120, 10'd70,  6'd5,  -1, 1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 11, 16'd1, 6'd32, 1'b0};
        vecs[1] = '{"corner", 10'd82,  10'd63,  6'd4,  -1, 1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 2,  16'd2, 6'd32, 1'b0};
        vecs[2] = '{"miss",   10'd320, 10'd300, 6'd8,  -1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 33, 16'd2, 6'd32, 1'b0};
        vecs[3] = '{"break",  10'd120, 10'd70,  6'd5,  -1, 1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 11, 16'd3, 6'd31, 1'b0};
        vecs[4] = '{"empty",  10'd120, 10'd70,  6'd5,  -1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 33, 16'd3, 6'd31, 1'b0};
        vecs[5] = '{"side",   10'd645, 10'd50,  6'd6,  -1, 1'b1, 1'b1, 1'b0, 2'd0, 3'd7, 9,  16'd4, 6'd31, 1'b0};
        vecs[6] = '{"clamp",  10'd3,   10'd115, 6'd10, -1, 1'b1, 1'b0, 1'b1, 2'd3, 3'd0, 26, 16'd5, 6'd31, 1'b0};
        vecs[7] = '{"ignore", 10'd320, 10'd300, 6'd8,  5,  1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 33, 16'd5, 6'd31, 1'b0};
        clear_vec = '{"clear", 10'd440, 10'd90, 6'd3,  -1, 1'b1, 1'b0, 1'b1, 2'd2, 3'd5, 23, 16'd6, 6'd0, 1'b1};

        reset = 1'b1; load = 1'b0; check = 1'b0; level_data = '0;
        ball_x = '0; ball_y = '0; radius = '0; rd_row = '0; rd_col = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        checkResetValues("reset");
        @(posedge clock); #1;

        applyLoad(FULL_TWO);
        checkOutput("load_left", 32'(bricks_left), 32'd32);
        checkOutput("load_clear", 32'(clear), 32'd0);
        readBack("load_rd_3_7", 2'd3, 3'd7, 2'd2);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        readBack("rd_1_1", 2'd1, 3'd1, 2'd0);
        readBack("rd_0_7", 2'd0, 3'd7, 2'd1);
        readBack("rd_0_0", 2'd0, 3'd0, 2'd1);
        readBack("rd_3_0", 2'd3, 3'd0, 2'd1);
        readBack("rd_3_7", 2'd3, 3'd7, 2'd2);

        // Single brick (2,5) of strength 1; the read port watches it across the hit edge.
        applyLoad(64'd1 << 42);
        checkOutput("single_left", 32'(bricks_left), 32'd1);
        checkOutput("single_clear", 32'(clear), 32'd0);
        rd_row = 2'd2;
        rd_col = 3'd5;
        applyStimulus(clear_vec);
        checkOutput("clear_rd_old", 32'(rd_strength), 32'd1);
        @(posedge clock); #1;
        checkOutput("clear_rd_new", 32'(rd_strength), 32'd0);

        level_data = FULL_TWO;
        ball_x = 10'd120; ball_y = 10'd70; radius = 6'd5;
        load = 1'b1;
        check = 1'b1;
        @(posedge clock); #1;
        load = 1'b0;
        check = 1'b0;
        checkOutput("loadcheck_busy", 32'(busy), 32'd0);
        checkOutput("loadcheck_left", 32'(bricks_left), 32'd32);
        checkOutput("loadcheck_clear", 32'(clear), 32'd0);
        checkOutput("loadcheck_score", 32'(score), 32'd6);
        @(posedge clock); #1;
        checkOutput("loadcheck_busy2", 32'(busy), 32'd0);

        ball_x = 10'd320; ball_y = 10'd300; radius = 6'd8;
        check = 1'b1;
        @(posedge clock); #1;
        check = 1'b0;
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        repeat (9) begin
            @(posedge clock); #1;
        end
        level_data = FULL_TWO;
        load = 1'b1;
        @(posedge clock); #1;
        load = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        countDone("abort_no_done", 40);
        checkOutput("abort_score", 32'(score), 32'd6);

        ball_x = 10'd120; ball_y = 10'd70; radius = 6'd5;
        check = 1'b1;
        @(posedge clock); #1;
        check = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        checkOutput("midreset_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkResetValues("midreset");
        countDone("midreset_no_done", 40);
        readBack("midreset_rd_0_0", 2'd0, 3'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
